// File: rtl/contador_de_programa.sv
// Fetch stage: owns the program counter, drives the instruction ROM address and
// registers the returned word into the IF/ID stage, with redirect, stall and halt handling.
module contador_de_programa #(
  parameter int                     PC_WIDTH     = 16,
  parameter logic [PC_WIDTH-1:0]    RESET_VECTOR = 16'h0000,
  parameter int                     PC_STEP      = 2,
  parameter logic [PC_WIDTH-1:0]    ROM_LAST     = 16'h001C
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                branchTaken,
  input  logic [PC_WIDTH-1:0] branchTarget,
  input  logic                jumpTaken,
  input  logic [PC_WIDTH-1:0] jumpTarget,
  input  logic [15:0]         instructionIn,
  output logic [PC_WIDTH-1:0] ProgramCounter,
  output logic [15:0]         instructionOut,
  output logic [PC_WIDTH-1:0] pcOut,
  output logic                validOut,
  output logic                haltOut,
  output logic                misalignOut,
  output logic [15:0]         fetchCount
);

  typedef enum logic {FETCH, HALT} state_t;

  state_t              state_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic [15:0]         instr_q;
  logic [PC_WIDTH-1:0] pcOut_q;
  logic                valid_q;
  logic                halt_q;
  logic                misalign_q;
  logic [15:0]         count_q;

  logic                redirect_d;
  logic [PC_WIDTH-1:0] target_d;
  logic [PC_WIDTH-1:0] pcInc_d;
  logic                inRom_d;
  logic                atLast_d;

  // Branch resolves in execute, so it belongs to the older instruction and wins.
  always_comb begin
    redirect_d = branchTaken | jumpTaken;
    target_d   = branchTaken ? branchTarget : jumpTarget;
    pcInc_d    = pc_q + PC_WIDTH'(PC_STEP);
    inRom_d    = (pc_q <= ROM_LAST);
    atLast_d   = (pc_q == ROM_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FETCH;
      pc_q       <= RESET_VECTOR;
      instr_q    <= 16'h0000;
      pcOut_q    <= '0;
      valid_q    <= 1'b0;
      halt_q     <= 1'b0;
      misalign_q <= 1'b0;
      count_q    <= 16'h0000;
    end else begin
      misalign_q <= 1'b0;
      if (redirect_d) begin
        pc_q       <= {target_d[PC_WIDTH-1:1], 1'b0};
        misalign_q <= target_d[0];
        instr_q    <= 16'h0000;
        valid_q    <= 1'b0;
        state_q    <= FETCH;
        halt_q     <= 1'b0;
      end else if (state_q == HALT) begin
        instr_q <= 16'h0000;
        valid_q <= 1'b0;
      end else if (!stall) begin
        if (inRom_d) begin
          instr_q <= instructionIn;
          pcOut_q <= pc_q;
          valid_q <= 1'b1;
          count_q <= count_q + 16'd1;
          if (atLast_d) begin
            state_q <= HALT;
            halt_q  <= 1'b1;
          end else begin
            pc_q <= pcInc_d;
          end
        end else begin
          // Only reachable after a redirect beyond the ROM: stop without fetching.
          instr_q <= 16'h0000;
          valid_q <= 1'b0;
          state_q <= HALT;
          halt_q  <= 1'b1;
        end
      end
    end
  end

  assign ProgramCounter = pc_q;
  assign instructionOut = instr_q;
  assign pcOut          = pcOut_q;
  assign validOut       = valid_q;
  assign haltOut        = halt_q;
  assign misalignOut    = misalign_q;
  assign fetchCount     = count_q;

endmodule

// File: tb/tb_contador_de_programa.sv
// Directed bench for contador_de_programa: sequential fetch, stall, redirect,
// misaligned target, end-of-ROM halt and asynchronous reset.
module tb_contador_de_programa;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branchTaken;
  logic [15:0] branchTarget;
  logic        jumpTaken;
  logic [15:0] jumpTarget;
  logic [15:0] instructionIn;
  logic [15:0] ProgramCounter;
  logic [15:0] instructionOut;
  logic [15:0] pcOut;
  logic        validOut;
  logic        haltOut;
  logic        misalignOut;
  logic [15:0] fetchCount;

  logic [15:0] rom [16];
  logic [66:0] obs;
  logic [66:0] exp;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  contador_de_programa dut (
    .clk(clk), .rst(rst), .stall(stall),
    .branchTaken(branchTaken), .branchTarget(branchTarget),
    .jumpTaken(jumpTaken), .jumpTarget(jumpTarget),
    .instructionIn(instructionIn), .ProgramCounter(ProgramCounter),
    .instructionOut(instructionOut), .pcOut(pcOut), .validOut(validOut),
    .haltOut(haltOut), .misalignOut(misalignOut), .fetchCount(fetchCount)
  );

  // Combinational ROM model indexed by PC[4:1]; word i holds 16'hA000+i.
  assign instructionIn = rom[ProgramCounter[4:1]];
  assign obs = {ProgramCounter, instructionOut, pcOut, validOut, haltOut, misalignOut, fetchCount};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 1'b0; branchTaken = 1'b0; jumpTaken = 1'b0;
    branchTarget = 16'h0000; jumpTarget = 16'h0000;
  endtask

  task automatic report(input string name);
    $display("[TB] FAIL %s got pc=%h ins=%h pcOut=%h v=%b h=%b m=%b cnt=%h exp pc=%h ins=%h pcOut=%h v=%b h=%b m=%b cnt=%h",
             name, obs[66:51], obs[50:35], obs[34:19], obs[18], obs[17], obs[16], obs[15:0],
             exp[66:51], exp[50:35], exp[34:19], exp[18], exp[17], exp[16], exp[15:0]);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    branchTaken = 1'b1; branchTarget = 16'h0013;
    rst = 1'b1;
    #2;
    exp = {16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000};
    total++; if (obs !== exp) begin bad++; report("reset_async"); end
    tick();
    total++; if (obs !== exp) begin bad++; report("reset_held"); end
    idle_inputs();
    rst = 1'b0;
  endtask

  task automatic test_sequential();
    do_reset();
    tick();
    exp = {16'h0002, 16'hA000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'd1};
    total++; if (obs !== exp) begin bad++; report("seq_edge1"); end
    tick();
    exp = {16'h0004, 16'hA001, 16'h0002, 1'b1, 1'b0, 1'b0, 16'd2};
    total++; if (obs !== exp) begin bad++; report("seq_edge2"); end
    tick();
    exp = {16'h0006, 16'hA002, 16'h0004, 1'b1, 1'b0, 1'b0, 16'd3};
    total++; if (obs !== exp) begin bad++; report("seq_edge3"); end
  endtask

  task automatic test_stall();
    do_reset();
    tick(); tick();
    stall = 1'b1;
    tick();
    exp = {16'h0004, 16'hA001, 16'h0002, 1'b1, 1'b0, 1'b0, 16'd2};
    total++; if (obs !== exp) begin bad++; report("stall_1"); end
    tick();
    total++; if (obs !== exp) begin bad++; report("stall_2"); end
    stall = 1'b0;
    tick();
    exp = {16'h0006, 16'hA002, 16'h0004, 1'b1, 1'b0, 1'b0, 16'd3};
    total++; if (obs !== exp) begin bad++; report("stall_release"); end
  endtask

  task automatic test_redirect();
    stall = 1'b1;
    branchTaken = 1'b1; branchTarget = 16'h0010;
    jumpTaken = 1'b1;   jumpTarget = 16'h0008;
    tick();
    exp = {16'h0010, 16'h0000, 16'h0004, 1'b0, 1'b0, 1'b0, 16'd3};
    total++; if (obs !== exp) begin bad++; report("redirect_branch_wins"); end
    idle_inputs();
    tick();
    exp = {16'h0012, 16'hA008, 16'h0010, 1'b1, 1'b0, 1'b0, 16'd4};
    total++; if (obs !== exp) begin bad++; report("redirect_fetch"); end
  endtask

  task automatic test_misalign();
    jumpTaken = 1'b1; jumpTarget = 16'h0007;
    tick();
    exp = {16'h0006, 16'h0000, 16'h0010, 1'b0, 1'b0, 1'b1, 16'd4};
    total++; if (obs !== exp) begin bad++; report("misalign_pulse"); end
    idle_inputs();
    tick();
    exp = {16'h0008, 16'hA003, 16'h0006, 1'b1, 1'b0, 1'b0, 16'd5};
    total++; if (obs !== exp) begin bad++; report("misalign_clear"); end
  endtask

  task automatic test_end_of_rom();
    logic [15:0] pc;
    logic [15:0] cnt;
    pc = 16'h0008; cnt = 16'd5;
    for (int i = 0; i < 10; i++) begin
      tick();
      cnt = cnt + 16'd1;
      exp = {pc + 16'd2, 16'hA000 + {1'b0, pc[15:1]}, pc, 1'b1, 1'b0, 1'b0, cnt};
      total++; if (obs !== exp) begin bad++; report("run_to_last"); end
      pc = pc + 16'd2;
    end
    tick();
    exp = {16'h001C, 16'hA00E, 16'h001C, 1'b1, 1'b1, 1'b0, 16'd16};
    total++; if (obs !== exp) begin bad++; report("last_word_halt"); end
    stall = 1'b1;
    tick();
    exp = {16'h001C, 16'h0000, 16'h001C, 1'b0, 1'b1, 1'b0, 16'd16};
    total++; if (obs !== exp) begin bad++; report("halt_bubble"); end
    stall = 1'b0;
    tick();
    total++; if (obs !== exp) begin bad++; report("halt_hold"); end
    branchTaken = 1'b1; branchTarget = 16'h0002;
    tick();
    exp = {16'h0002, 16'h0000, 16'h001C, 1'b0, 1'b0, 1'b0, 16'd16};
    total++; if (obs !== exp) begin bad++; report("halt_exit"); end
    idle_inputs();
    jumpTaken = 1'b1; jumpTarget = 16'h001E;
    tick();
    exp = {16'h001E, 16'h0000, 16'h001C, 1'b0, 1'b0, 1'b0, 16'd16};
    total++; if (obs !== exp) begin bad++; report("beyond_rom_redirect"); end
    idle_inputs();
    tick();
    exp = {16'h001E, 16'h0000, 16'h001C, 1'b0, 1'b1, 1'b0, 16'd16};
    total++; if (obs !== exp) begin bad++; report("beyond_rom_halt"); end
  endtask

  task automatic test_async_reset_mid();
    jumpTaken = 1'b1; jumpTarget = 16'h0008;
    tick();
    idle_inputs();
    tick();
    exp = {16'h000A, 16'hA004, 16'h0008, 1'b1, 1'b0, 1'b0, 16'd17};
    total++; if (obs !== exp) begin bad++; report("pre_reset_state"); end
    #2;
    rst = 1'b1;
    #1;
    exp = {16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000};
    total++; if (obs !== exp) begin bad++; report("reset_mid_async"); end
    tick();
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 16'hA000 + 16'(i);
    idle_inputs();
    rst = 1'b0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_misalign();
    test_end_of_rom();
    test_async_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
